// File: rtl/noise_pkg.sv
// Shared encodings for the noise-waveform RAM address sequencer.
package noise_pkg;

  localparam int unsigned ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/noise_step_cmp.sv
// Next-address adder and end-of-window detect; step of 0 advances by 1.
module noise_step_cmp #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned STEP_W = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [STEP_W-1:0] step,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] nxt_c,
  output logic              over_c
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [STEP_W-1:0] step_eff;
  logic [SUM_W-1:0]  sum;

  // Extra sum bit catches overflow past the top of the RAM as a boundary.
  always_comb begin
    step_eff = (step == '0) ? STEP_W'(1) : step;
    sum      = SUM_W'(addr) + SUM_W'(step_eff);
    nxt_c    = sum[ADDR_W-1:0];
    over_c   = (sum > SUM_W'(end_addr));
  end

endmodule

// File: rtl/noise_addr_seq.sv
// Programmable-window address sequencer for the noise-waveform RAM with
// continuous/single-pass modes, wrap pulse and saturating pass counter.
module noise_addr_seq
  import noise_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [STEP_W-1:0] step,
  input  logic              mode,
  input  logic              run,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic              wrap_p,
  output logic              done,
  output logic              busy,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  pass_cnt
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] start_q, end_q;
  logic [STEP_W-1:0] step_q;
  logic              mode_q;

  logic [ADDR_W-1:0] addr_nxt;
  logic              wrap_nxt, done_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [ADDR_W-1:0] step_addr;
  logic              over;

  noise_step_cmp #(
    .ADDR_W (ADDR_W),
    .STEP_W (STEP_W)
  ) u_step_cmp (
    .addr     (addr),
    .step     (step_q),
    .end_addr (end_q),
    .nxt_c    (step_addr),
    .over_c   (over)
  );

  // Latched window configuration and its validity flag.
  always_ff @(posedge clkin) begin
    if (rst) begin
      start_q <= '0;
      end_q   <= '1;
      step_q  <= STEP_W'(1);
      mode_q  <= MODE_WRAP;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      start_q <= start_addr;
      end_q   <= end_addr;
      step_q  <= step;
      mode_q  <= mode;
      cfg_err <= (start_addr > end_addr);
    end
  end

  // State and sequencing registers.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      wrap_p   <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      wrap_p   <= wrap_nxt;
      done     <= done_nxt;
      pass_cnt <= cnt_nxt;
    end
  end

  // Next-state and next-value logic; cfg_load outranks clr outranks run.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    wrap_nxt  = 1'b0;
    done_nxt  = done;
    cnt_nxt   = pass_cnt;
    addr_vld  = (state == ST_RUN) && run;
    busy      = (state == ST_RUN);

    if (cfg_load) begin
      state_nxt = ST_IDLE;
      addr_nxt  = start_addr;
      done_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else if (clr) begin
      state_nxt = ST_IDLE;
      addr_nxt  = start_q;
      done_nxt  = 1'b0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run && !cfg_err) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (run) begin
            if (over) begin
              cnt_nxt = (&pass_cnt) ? pass_cnt : pass_cnt + CNT_W'(1);
              if (mode_q == MODE_WRAP) begin
                addr_nxt = start_q;
                wrap_nxt = 1'b1;
              end else begin
                done_nxt  = 1'b1;
                state_nxt = ST_DONE;
              end
            end else begin
              addr_nxt = step_addr;
            end
          end
        end
        ST_DONE: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_addr_seq.sv
// Randomised self-checking bench for noise_addr_seq against a window/step model.
module tb_noise_addr_seq;

  logic        clkin;
  logic        rst, cfg_load, mode, run, clr;
  logic [11:0] start_addr, end_addr;
  logic [3:0]  step;
  logic [11:0] addr;
  logic        addr_vld, wrap_p, done, busy, cfg_err;
  logic [7:0]  pass_cnt;

  int tests = 0;
  int fails = 0;

  // Behavioural model: phase 0 idle, 1 running, 2 finished.
  int m_start, m_end, m_step, m_addr, m_phase, m_pass;
  bit m_mode, m_err, m_wrap, m_done;

  noise_addr_seq dut (
    .clkin      (clkin),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .step       (step),
    .mode       (mode),
    .run        (run),
    .clr        (clr),
    .addr       (addr),
    .addr_vld   (addr_vld),
    .wrap_p     (wrap_p),
    .done       (done),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .pass_cnt   (pass_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  function automatic logic [24:0] obs();
    return {addr, addr_vld, wrap_p, done, busy, cfg_err, pass_cnt};
  endfunction

  function automatic logic [24:0] expv();
    logic vld, bsy;
    vld = (m_phase == 1) && (run === 1'b1);
    bsy = (m_phase == 1);
    return {12'(m_addr), vld, m_wrap, m_done, bsy, m_err, 8'(m_pass)};
  endfunction

  task automatic model_edge();
    int st;
    if (rst) begin
      m_start = 0; m_end = 4095; m_step = 1; m_mode = 0; m_err = 0;
      m_addr = 0; m_phase = 0; m_pass = 0; m_wrap = 0; m_done = 0;
    end else if (cfg_load) begin
      m_start = int'(start_addr); m_end = int'(end_addr);
      m_step = int'(step); m_mode = mode; m_err = (start_addr > end_addr);
      m_addr = m_start; m_phase = 0; m_pass = 0; m_wrap = 0; m_done = 0;
    end else if (clr) begin
      m_addr = m_start; m_phase = 0; m_pass = 0; m_wrap = 0; m_done = 0;
    end else begin
      m_wrap = 0;
      if (m_phase == 0) begin
        if (run && !m_err) m_phase = 1;
      end else if (m_phase == 1 && run) begin
        st = (m_step == 0) ? 1 : m_step;
        if (m_addr + st <= m_end) m_addr = m_addr + st;
        else begin
          if (m_pass < 255) m_pass++;
          if (!m_mode) begin m_addr = m_start; m_wrap = 1; end
          else begin m_done = 1; m_phase = 2; end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    model_edge();
    #1;
  endtask

  task automatic do_cfg(input int s, input int e, input int st, input bit md);
    start_addr = 12'(s); end_addr = 12'(e); step = 4'(st); mode = md;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_load = 1'b1; run = 1'b1; clr = 1'b0;
    start_addr = 12'd300; end_addr = 12'd10; step = 4'd2; mode = 1'b1;
    tick();
    tests++;
    if (obs() !== 25'h0) begin
      fails++; $display("FAIL reset got=%h exp=%h", obs(), 25'h0);
    end
    rst = 1'b0; cfg_load = 1'b0; run = 1'b0;
    tick();
  endtask

  task automatic test_full_sweep();
    run = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      tick();
      tests++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL full_sweep cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    tests++;
    if (pass_cnt !== 8'd1) begin
      fails++; $display("FAIL sweep_pass_cnt got=%0d exp=1", pass_cnt);
    end
    run = 1'b0;
  endtask

  task automatic test_wrap_window();
    do_cfg(100, 110, 3, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL wrap_window cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    run = 1'b0;
  endtask

  task automatic test_single_pass();
    do_cfg(100, 110, 3, 1'b1);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL single_pass cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    tests++;
    if (addr !== 12'd109 || done !== 1'b1) begin
      fails++; $display("FAIL single_end addr=%0d done=%b exp 109/1", addr, done);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tests++;
    if (obs() !== expv() || addr !== 12'd100 || done !== 1'b0) begin
      fails++; $display("FAIL single_clr got=%h exp=%h", obs(), expv());
    end
    run = 1'b0;
  endtask

  task automatic test_pause();
    logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_cfg(1000, 1040, 5, 1'b0);
    for (int i = 0; i < 60; i++) begin
      run = (i < 8) ? pat[i] : logic'($urandom_range(0, 1));
      tick();
      tests++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL pause cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    run = 1'b0;
  endtask

  task automatic test_cfg_err();
    do_cfg(200, 50, 1, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (obs() !== expv() || busy !== 1'b0 || cfg_err !== 1'b1) begin
        fails++; $display("FAIL cfg_err cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    do_cfg(50, 200, 1, 1'b0);
    tests++;
    if (cfg_err !== 1'b0 || obs() !== expv()) begin
      fails++; $display("FAIL cfg_err_clear got=%h exp=%h", obs(), expv());
    end
    run = 1'b0;
  endtask

  task automatic test_collision();
    do_cfg(10, 60, 7, 1'b0);
    run = 1'b1;
    repeat (4) tick();
    start_addr = 12'd2000; end_addr = 12'd2100; step = 4'd1; mode = 1'b0;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tests++;
    if (obs() !== expv() || addr !== 12'd2000 || busy !== 1'b0) begin
      fails++; $display("FAIL collision_cfg got=%h exp=%h", obs(), expv());
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL collision_run cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    rst = 1'b1; cfg_load = 1'b1;
    tick();
    rst = 1'b0; cfg_load = 1'b0;
    tests++;
    if (obs() !== {12'd0, run === 1'b1 && 1'b0, 12'd0}) begin
      fails++; $display("FAIL collision_rst got=%h exp=%h", obs(), 25'h0);
    end
    run = 1'b0;
  endtask

  task automatic test_saturate();
    do_cfg(500, 500, 5, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      tests++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL saturate cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    tests++;
    if (pass_cnt !== 8'hff) begin
      fails++; $display("FAIL saturate_final got=%0d exp=255", pass_cnt);
    end
    run = 1'b0;
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cfg_load = ($urandom_range(0, 149) == 0);
      if (cfg_load) begin
        s = int'($urandom_range(0, 4095));
        start_addr = 12'(s);
        if ($urandom_range(0, 9) == 0) end_addr = 12'($urandom_range(0, 4095));
        else end_addr = 12'((s + int'($urandom_range(0, 40)) > 4095) ? 4095 : s + int'($urandom_range(0, 40)));
        step = 4'($urandom_range(0, 15));
        mode = logic'($urandom_range(0, 1));
      end
      tick();
      tests++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    run = 1'b0; clr = 1'b0; rst = 1'b0; cfg_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; run = 1'b0; clr = 1'b0; mode = 1'b0;
    start_addr = '0; end_addr = '0; step = '0;
    test_reset();
    test_full_sweep();
    test_wrap_window();
    test_single_pass();
    test_pause();
    test_cfg_err();
    test_collision();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
